// File: rtl/vreg_pkg.sv
// rtl/vreg_pkg.sv - shared sizes and types for the vector register file
package vreg_pkg;

    localparam int VREG_COUNT = 8;
    localparam int VREG_IDX_W = 3;
    localparam int DEF_LANES  = 4;
    localparam int DEF_DATA_W = 8;

    typedef logic [VREG_IDX_W-1:0] vreg_idx_t;
    typedef logic [DEF_DATA_W-1:0] lane_t;
    typedef lane_t [DEF_LANES-1:0] vec_t;

endpackage

// File: rtl/vreg_scoreboard.sv
// rtl/vreg_scoreboard.sv - per-register busy bits and RAW/WAW issue stall
module vreg_scoreboard
    import vreg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bypass_en,
    input  logic                  issue_valid,
    input  logic                  rs1_en,
    input  logic [VREG_IDX_W-1:0] rs1_idx,
    input  logic                  rs2_en,
    input  logic [VREG_IDX_W-1:0] rs2_idx,
    input  logic                  rd_en,
    input  logic [VREG_IDX_W-1:0] rd_idx,
    input  logic                  wb_en,
    input  logic [VREG_IDX_W-1:0] wb_idx,
    output logic                  stall,
    output logic [VREG_COUNT-1:0] busy_vec
);

    logic [VREG_COUNT-1:0] busy;
    logic [VREG_COUNT-1:0] busy_nxt;
    logic [VREG_COUNT-1:0] hz;

    // A write-back landing this cycle only hides the hazard when it is forwarded.
    always_comb begin
        hz = '0;
        for (int i = 0; i < VREG_COUNT; i++) begin
            hz[i] = busy[i] & ~(bypass_en & wb_en & (wb_idx == vreg_idx_t'(i)));
        end
    end

    assign stall = issue_valid & ((rs1_en & hz[rs1_idx]) |
                                  (rs2_en & hz[rs2_idx]) |
                                  (rd_en  & hz[rd_idx]));

    // Set is applied after clear: a newly issued producer owns the register.
    always_comb begin
        busy_nxt = busy;
        if (wb_en) begin
            busy_nxt[wb_idx] = 1'b0;
        end
        if (issue_valid && !stall && rd_en) begin
            busy_nxt[rd_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/vectorial_reg_file.sv
// rtl/vectorial_reg_file.sv - 8-entry vector register file, 2R/1W lane-masked, busy scoreboard; VREG_BYPASS_EN enables write-back forwarding
module vectorial_reg_file
    import vreg_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid,
    input  logic                    rs1_en,
    input  logic [2:0]              rs1_idx,
    input  logic                    rs2_en,
    input  logic [2:0]              rs2_idx,
    input  logic                    rd_en,
    input  logic [2:0]              rd_idx,
    input  logic                    wb_en,
    input  logic [2:0]              wb_idx,
    input  logic [LANES-1:0]        wb_mask,
    input  logic [LANES*DATA_W-1:0] wb_data,
    output logic [LANES*DATA_W-1:0] rd1_data,
    output logic [LANES*DATA_W-1:0] rd2_data,
    output logic                    stall,
    output logic [7:0]              busy_vec
);

`ifdef VREG_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic [LANES*DATA_W-1:0] regs [VREG_COUNT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < VREG_COUNT; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (wb_mask[l]) begin
                    regs[wb_idx][l*DATA_W +: DATA_W] <= wb_data[l*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Reads are gated by rst_n so they show zero even before the first reset edge.
    always_comb begin
        rd1_data = '0;
        rd2_data = '0;
        for (int l = 0; l < LANES; l++) begin
            if (rst_n && rs1_en) begin
                if (BYPASS && wb_en && wb_idx == rs1_idx && wb_mask[l]) begin
                    rd1_data[l*DATA_W +: DATA_W] = wb_data[l*DATA_W +: DATA_W];
                end else begin
                    rd1_data[l*DATA_W +: DATA_W] = regs[rs1_idx][l*DATA_W +: DATA_W];
                end
            end
            if (rst_n && rs2_en) begin
                if (BYPASS && wb_en && wb_idx == rs2_idx && wb_mask[l]) begin
                    rd2_data[l*DATA_W +: DATA_W] = wb_data[l*DATA_W +: DATA_W];
                end else begin
                    rd2_data[l*DATA_W +: DATA_W] = regs[rs2_idx][l*DATA_W +: DATA_W];
                end
            end
        end
    end

    vreg_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .bypass_en   (BYPASS),
        .issue_valid (issue_valid),
        .rs1_en      (rs1_en),
        .rs1_idx     (rs1_idx),
        .rs2_en      (rs2_en),
        .rs2_idx     (rs2_idx),
        .rd_en       (rd_en),
        .rd_idx      (rd_idx),
        .wb_en       (wb_en),
        .wb_idx      (wb_idx),
        .stall       (stall),
        .busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_vectorial_reg_file.sv
// tb/tb_vectorial_reg_file.sv - scoreboard-driven bench for vectorial_reg_file
module tb_vectorial_reg_file;

`ifdef VREG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RD1  = 0;
    localparam int K_RD2  = 1;
    localparam int K_STL  = 2;
    localparam int K_BUSY = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        rs1_en;
    logic [2:0]  rs1_idx;
    logic        rs2_en;
    logic [2:0]  rs2_idx;
    logic        rd_en;
    logic [2:0]  rd_idx;
    logic        wb_en;
    logic [2:0]  wb_idx;
    logic [3:0]  wb_mask;
    logic [31:0] wb_data;
    logic [31:0] rd1_data;
    logic [31:0] rd2_data;
    logic        stall;
    logic [7:0]  busy_vec;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    vectorial_reg_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .rs1_en      (rs1_en),
        .rs1_idx     (rs1_idx),
        .rs2_en      (rs2_en),
        .rs2_idx     (rs2_idx),
        .rd_en       (rd_en),
        .rd_idx      (rd_idx),
        .wb_en       (wb_en),
        .wb_idx      (wb_idx),
        .wb_mask     (wb_mask),
        .wb_data     (wb_data),
        .rd1_data    (rd1_data),
        .rd2_data    (rd2_data),
        .stall       (stall),
        .busy_vec    (busy_vec)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic expect_out(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Outputs are sampled on the falling edge, mid-way between input updates.
    task automatic cycle();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_RD1:   obs = rd1_data;
                K_RD2:   obs = rd2_data;
                K_STL:   obs = {31'b0, stall};
                default: obs = {24'b0, busy_vec};
            endcase
            check_vec(e.tag, obs, e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; rs1_en = 0; rs1_idx = 0; rs2_en = 0; rs2_idx = 0;
        rd_en = 0; rd_idx = 0; wb_en = 0; wb_idx = 0; wb_mask = 0; wb_data = 0;
    endtask

    task automatic issue(input logic e1, input logic [2:0] i1, input logic e2,
                         input logic [2:0] i2, input logic ed, input logic [2:0] id);
        issue_valid = 1; rs1_en = e1; rs1_idx = i1; rs2_en = e2; rs2_idx = i2;
        rd_en = ed; rd_idx = id;
    endtask

    task automatic wb(input logic [2:0] idx, input logic [3:0] mask, input logic [31:0] data);
        wb_en = 1; wb_idx = idx; wb_mask = mask; wb_data = data;
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk);
        #1;

        // reset, then read a register
        rs1_en = 1; rs1_idx = 5;
        expect_out("rst_rd1", K_RD1, 32'h0);
        expect_out("rst_busy", K_BUSY, 32'h0);
        expect_out("rst_stall", K_STL, 32'h0);
        cycle();
        rst_n = 1;
        expect_out("post_rst_rd1", K_RD1, 32'h0);
        expect_out("post_rst_busy", K_BUSY, 32'h0);
        cycle();

        // masked write-back into reg 2
        idle();
        wb(3'd2, 4'b1111, 32'hAABBCCDD);
        expect_out("wb_full_rd1_off", K_RD1, 32'h0);
        cycle();
        wb(3'd2, 4'b0101, 32'h11223344);
        rs1_en = 1; rs1_idx = 2;
        expect_out("wb_mask_fwd", K_RD1, BYP ? 32'hAA22CC44 : 32'hAABBCCDD);
        cycle();
        idle();
        rs2_en = 1; rs2_idx = 2;
        expect_out("wb_mask_rd2", K_RD2, 32'hAA22CC44);
        expect_out("wb_busy", K_BUSY, 32'h0);
        cycle();

        // RAW on reg 3
        idle();
        issue(0, 0, 0, 0, 1, 3'd3);
        expect_out("raw_prod_stall", K_STL, 32'h0);
        cycle();
        issue(1, 3'd3, 0, 0, 0, 0);
        expect_out("raw_busy", K_BUSY, 32'h08);
        expect_out("raw_stall_a", K_STL, 32'h1);
        cycle();
        expect_out("raw_stall_b", K_STL, 32'h1);
        cycle();
        wb(3'd3, 4'b1111, 32'h12345678);
        expect_out("raw_wb_stall", K_STL, BYP ? 32'h0 : 32'h1);
        expect_out("raw_wb_rd1", K_RD1, BYP ? 32'h12345678 : 32'h0);
        expect_out("raw_wb_busy", K_BUSY, 32'h08);
        cycle();
        wb_en = 0;
        expect_out("raw_after_stall", K_STL, 32'h0);
        expect_out("raw_after_rd1", K_RD1, 32'h12345678);
        expect_out("raw_after_busy", K_BUSY, 32'h0);
        cycle();

        // WAW on reg 4 and set-wins
        idle();
        issue(0, 0, 0, 0, 1, 3'd4);
        expect_out("waw_prod_stall", K_STL, 32'h0);
        cycle();
        expect_out("waw_stall", K_STL, 32'h1);
        expect_out("waw_busy", K_BUSY, 32'h10);
        cycle();
        wb(3'd4, 4'b0000, 32'hFFFFFFFF);
        expect_out("waw_wb_stall", K_STL, BYP ? 32'h0 : 32'h1);
        expect_out("waw_wb_busy", K_BUSY, 32'h10);
        cycle();
        idle();
        expect_out("set_wins_busy", K_BUSY, BYP ? 32'h10 : 32'h00);
        cycle();
        if (!BYP) begin
            issue(0, 0, 0, 0, 1, 3'd4);
            expect_out("reissue4_stall", K_STL, 32'h0);
            cycle();
        end

        // disabled source port pointing at a busy register
        idle();
        issue(0, 0, 0, 0, 1, 3'd6);
        cycle();
        issue(0, 0, 0, 3'd6, 0, 0);
        expect_out("dis_busy", K_BUSY, 32'h50);
        expect_out("dis_stall", K_STL, 32'h0);
        expect_out("dis_rd2", K_RD2, 32'h0);
        cycle();
        issue(0, 0, 1, 3'd6, 0, 0);
        expect_out("en_rs2_stall", K_STL, 32'h1);
        cycle();

        // fill busy to F0, then reset with a write-back in flight
        idle();
        issue(0, 0, 0, 0, 1, 3'd5);
        cycle();
        issue(0, 0, 0, 0, 1, 3'd7);
        cycle();
        idle();
        rst_n = 0;
        wb(3'd2, 4'b1111, 32'hFFFFFFFF);
        rs1_en = 1; rs1_idx = 2;
        expect_out("mid_rst_busy", K_BUSY, 32'hF0);
        expect_out("mid_rst_rd1", K_RD1, 32'h0);
        cycle();
        rst_n = 1;
        wb_en = 0;
        expect_out("mid_rst_after_busy", K_BUSY, 32'h0);
        expect_out("mid_rst_dropped", K_RD1, 32'h0);
        cycle();

        // equal sources and rd == rs
        idle();
        wb(3'd7, 4'b1111, 32'hCAFEBABE);
        cycle();
        idle();
        issue(1, 3'd7, 1, 3'd7, 1, 3'd7);
        expect_out("same_src_stall", K_STL, 32'h0);
        expect_out("same_src_rd1", K_RD1, 32'hCAFEBABE);
        expect_out("same_src_rd2", K_RD2, 32'hCAFEBABE);
        cycle();
        idle();
        expect_out("rd_eq_rs_busy", K_BUSY, 32'h80);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/vectorial_reg_file.md
Name: vectorial_reg_file

Overview:
- Vector register file for the interpolation ASIP.
- Consumes the physical vector indices 0-7 that the decode stage produces from architectural registers v16-v23.
- Holds 8 vector registers, each LANES x DATA_W bits.
- Provides 2 read ports and 1 lane-masked write-back port.
- Keeps a per-register busy scoreboard that stalls issue on RAW and WAW hazards against in-flight vector results.

Parameters:
- LANES, 4, number of lanes per vector register
- DATA_W, 8, bits per lane (pixel width)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- issue_valid  in  1  decode presents an instruction this cycle
- rs1_en  in  1  instruction reads vector source 1
- rs1_idx  in  3  physical index of source 1
- rs2_en  in  1  instruction reads vector source 2
- rs2_idx  in  3  physical index of source 2
- rd_en  in  1  instruction writes a vector destination
- rd_idx  in  3  physical index of the destination
- wb_en  in  1  write-back strobe
- wb_idx  in  3  write-back physical index
- wb_mask  in  LANES  per-lane write enable
- wb_data  in  LANES*DATA_W  write-back data; lane 0 at the LSBs
- rd1_data  out  LANES*DATA_W  source 1 data
- rd2_data  out  LANES*DATA_W  source 2 data
- stall  out  1  issue must hold this cycle
- busy_vec  out  8  scoreboard state; bit i = register i has a pending write

Behaviour:
- Clocking and reset:
  - Single clock: clk.
  - Reset is synchronous and active-low on rst_n.
  - While rst_n=0 at a rising edge: all 8 registers become 0 and busy_vec becomes 0.
  - Reset mid-operation discards pending writes; a wb_en in the reset cycle is ignored.
  - Output values during and immediately after reset: rd1_data and rd2_data are 0; busy_vec is 0; stall=0 unless issue_valid requests a busy register (none are busy after reset).
- Reads:
  - Combinational, zero latency.
  - rdN_data = reg[rsN_idx] when rsN_en=1, otherwise all zeros.
- Write-back:
  - Takes effect at the rising edge.
  - For each lane l with wb_mask[l]=1: lane l of reg[wb_idx] <= wb_data lane l. Unmasked lanes keep their value.
  - busy[wb_idx] clears, even when wb_mask=0.
  - Writing a non-busy register is legal (used by the load path); busy stays 0.
- Hazard detection (combinational):
  - hz(i) = busy[i] AND NOT (wb_en AND wb_idx==i AND bypass active).
  - stall = issue_valid AND ((rs1_en AND hz(rs1_idx)) OR (rs2_en AND hz(rs2_idx)) OR (rd_en AND hz(rd_idx))).
- Issue:
  - Accepted when issue_valid=1 and stall=0.
  - If rd_en=1, busy[rd_idx] <= 1 at the edge.
- Simultaneous events:
  - Set and clear on the same index in the same edge: set wins, because a new producer takes over the register.
  - Two sources equal to each other, or a source equal to rd: each is checked independently; no extra stall.
  - rd_idx equal to rs1_idx on an accepted issue (e.g. v16 <- v16 op v17): the read returns the old value and the busy bit is set.
- busy_vec is the registered scoreboard and does not include same-cycle effects.

Optional Feature:
- Macro: VREG_BYPASS_EN.
- Defined:
  - A same-cycle write-back forwards into reads. For each lane with wb_en=1, wb_idx==rsN_idx and the mask bit set, rdN_data takes the wb_data lane; other lanes read from the register.
  - The matching busy bit is treated as clear for the stall computation.
- Undefined:
  - No forwarding, and the bypass term in hz() is never active.
  - An instruction that depends on a same-cycle write-back stalls one extra cycle and reads the written value on the next cycle.

Decomposition:
- Package vreg_pkg:
  - VREG_COUNT=8, VREG_IDX_W=3.
  - Default LANES and DATA_W.
  - typedef vreg_idx_t (logic [2:0]).
  - typedef lane_t (logic [DATA_W-1:0]).
  - typedef vec_t (lane_t [LANES-1:0]).
- One sub-module, vreg_scoreboard:
  - Holds the busy bits.
  - Implements the set/clear priority and stall generation.
  - Takes the bypass qualifier as an input.
- Storage, read muxing and forwarding stay in the top module.

Test Plan:
- Reset then read: rst_n=0 for 2 cycles; rs1_en=1, rs1_idx=5 -> rd1_data=0, busy_vec=8'h00, stall=0.
- Masked write: wb_en=1, wb_idx=2, wb_data=32'hAABBCCDD, wb_mask=4'b1111; next cycle wb_mask=4'b0101, wb_data=32'h11223344 -> reg2 reads 32'hAA22CC44.
- RAW stall: accepted issue with rd_en=1, rd_idx=3 -> busy_vec=8'h08. Next issue with rs1_en=1, rs1_idx=3 -> stall=1 until wb_idx=3, then stall=0.
  - With VREG_BYPASS_EN: stall drops in the write-back cycle and rd1_data equals wb_data in that cycle.
  - Without it: stall drops one cycle later.
- WAW and set-wins: busy[4]=1. Issue rd_idx=4 -> stall=1. With bypass and wb_idx=4 in the same cycle -> issue accepted and busy[4] is still 1 afterwards.
- Disabled ports: rs2_en=0 with rs2_idx pointing at a busy register -> stall=0 and rd2_data=0.
- Reset mid-flight: busy_vec=8'hF0 and wb_en=1 in the reset cycle -> busy_vec=8'h00 and the write is dropped.
